// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the FIFO word serializer.
package fifo_pkg;

    // Serializer control states: waiting for a word, or emitting its slices.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Number of OUT_WIDTH slices in one DATA_WIDTH word (0 if OUT_WIDTH is 0).
    function automatic int unsigned calc_ratio(input int unsigned data_width,
                                               input int unsigned out_width);
        if (out_width == 0) begin
            return 0;
        end
        return data_width / out_width;
    endfunction

    // Width of the slice counter; never narrower than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned ratio);
        if (ratio < 2) begin
            return 1;
        end
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops words from a first-word-fall-through FIFO and emits them as a stream of
// OUT_WIDTH slices with valid/ready handshake, without bubbles between words.
module fifo_word_serializer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  fifo_read_o,
    output logic [OUT_WIDTH-1:0]  out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int unsigned RATIO = calc_ratio(DATA_WIDTH, OUT_WIDTH);
    localparam int unsigned CNT_W = calc_cnt_w(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    // Refuse to build a serializer whose word does not split into >= 2 whole slices.
    generate
        if (OUT_WIDTH == 0 || (DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
            $error("fifo_word_serializer: DATA_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
        end
    endgenerate

    state_e                              r_state;
    state_e                              w_state_nxt;
    logic [CNT_W-1:0]                    r_cnt;
    logic [CNT_W-1:0]                    w_cnt_nxt;
    logic [DATA_WIDTH-1:0]               r_hold;
    logic [DATA_WIDTH-1:0]               w_hold_nxt;
    logic                                w_read;
    logic                                w_shift;
    logic                                w_at_last;
    logic [CNT_W-1:0]                    w_sel;
    logic [RATIO-1:0][OUT_WIDTH-1:0]     w_slices;

    assign w_shift   = (r_state == SHIFT);
    assign w_at_last = (r_cnt == CNT_LAST);

    // Slice 0 is the bottom slice for LSB_FIRST, otherwise the top slice.
    assign w_sel    = LSB_FIRST ? r_cnt : (CNT_LAST - r_cnt);
    assign w_slices = r_hold;

    // Next-state, counter and holding-register update; a pop always reloads the word.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_read      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!fifo_empty_i) begin
                    w_read      = 1'b1;
                    w_hold_nxt  = fifo_rd_data_i;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready_i) begin
                    if (!w_at_last) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else if (!fifo_empty_i) begin
                        // Chain straight into the next word to avoid a bubble.
                        w_read     = 1'b1;
                        w_hold_nxt = fifo_rd_data_i;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode; the pop is masked during reset so no word is lost while held.
    always_comb begin
        fifo_read_o = w_read & ~rst_i;
        out_valid_o = w_shift;
        busy_o      = w_shift;
        out_last_o  = w_shift & w_at_last;
        out_data_o  = w_shift ? w_slices[w_sel] : '0;
    end

    // State, counter and holding register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Self-checking bench: FWFT FIFO model plus slice scoreboard for the serializer.
module tb_fifo_word_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // LSB-first DUT, fed by the queue-based FIFO model
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_read;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;

    // MSB-first DUT, driven directly
    logic        m_empty = 1'b1;
    logic [31:0] m_data = '0;
    logic        m_read;
    logic [7:0]  m_out;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic        m_busy;

    fifo_word_serializer #(
        .DATA_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fifo_empty_i  (fifo_empty),
        .fifo_rd_data_i(fifo_rd_data),
        .fifo_read_o   (fifo_read),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_last_o    (out_last),
        .busy_o        (busy)
    );

    fifo_word_serializer #(
        .DATA_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)
    ) u_dut_msb (
        .clk_i         (clk),
        .rst_i         (rst),
        .fifo_empty_i  (m_empty),
        .fifo_rd_data_i(m_data),
        .fifo_read_o   (m_read),
        .out_data_o    (m_out),
        .out_valid_o   (m_valid),
        .out_ready_i   (m_ready),
        .out_last_o    (m_last),
        .busy_o        (m_busy)
    );

    logic [31:0] fifo_q[$];
    logic [8:0]  sb_q[$];       // {last, data}
    logic [8:0]  exp_s;
    int          errors = 0;
    int          checks = 0;
    int          xfer_cnt = 0;
    int          pop_cnt = 0;
    logic [7:0]  pop_data = '0;
    bit          pop_pending = 1'b0;

    function automatic void refresh();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? 32'h0 : fifo_q[0];
    endfunction

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back({(i == 3), w[i*8 +: 8]});
        end
        refresh();
    endtask

    // FIFO pop, applied just after the edge on which the DUT took the word
    always @(posedge clk) begin
        #1;
        if (pop_pending) begin
            pop_pending = 1'b0;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            refresh();
        end
    end

    // Monitor: pop legality and scoreboard compare on every transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_read) begin
                checks++;
                if (fifo_empty) begin
                    errors++;
                    $display("FAIL read_while_empty: fifo_read_o=1 with fifo_empty_i=1");
                end
                pop_cnt++;
                pop_pending = 1'b1;
                pop_data = out_data;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_slice: got last=%0b data=%02h, expected none",
                             out_last, out_data);
                end else begin
                    exp_s = sb_q.pop_front();
                    if ({out_last, out_data} !== exp_s) begin
                        errors++;
                        $display("FAIL slice: got last=%0b data=%02h, expected last=%0b data=%02h",
                                 out_last, out_data, exp_s[8], exp_s[7:0]);
                    end
                end
                xfer_cnt++;
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        push_word(32'hAABBCCDD);
        #1;
        checks++;
        if ({fifo_read, out_valid, out_last, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: read/valid/last/busy=%04b, expected 0000",
                     {fifo_read, out_valid, out_last, busy});
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %02h, expected 00", out_data);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_single_word();
        int base_pop;
        int nv;
        base_pop = pop_cnt;
        nv = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        checks++;
        if (nv !== 4) begin
            errors++;
            $display("FAIL single_valid_cycles: got %0d, expected 4", nv);
        end
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL single_drain: %0d slices left, expected 0", sb_q.size());
        end
        checks++;
        if (pop_cnt - base_pop !== 1) begin
            errors++;
            $display("FAIL single_pops: got %0d, expected 1", pop_cnt - base_pop);
        end
    endtask

    task automatic test_back_to_back();
        int base_pop;
        int nv;
        int first;
        int last;
        base_pop = pop_cnt;
        nv = 0;
        first = -1;
        last = -1;
        @(posedge clk);
        #1;
        push_word(32'h03020100);
        push_word(32'h07060504);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (out_valid) begin
                nv++;
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++;
        if (nv !== 8 || (last - first + 1) !== 8) begin
            errors++;
            $display("FAIL b2b_throughput: %0d valid over span %0d, expected 8 over 8",
                     nv, last - first + 1);
        end
        checks++;
        if (pop_cnt - base_pop !== 2) begin
            errors++;
            $display("FAIL b2b_pops: got %0d, expected 2", pop_cnt - base_pop);
        end
        checks++;
        if (pop_data !== 8'h03) begin
            errors++;
            $display("FAIL b2b_pop_slice: second pop with %02h, expected 03", pop_data);
        end
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d slices left, expected 0", sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        int base_pop;
        bit found;
        base_pop = pop_cnt;
        found = 1'b0;
        @(posedge clk);
        #1;
        push_word(32'hAABBCCDD);
        push_word(32'h44332211);
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_data == 8'hCC) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stall_reach_cc: slice CC not presented, expected within 10 cycles");
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_last, fifo_read, out_data} !== {3'b100, 8'hCC}) begin
                errors++;
                $display("FAIL stall_hold: valid/last/read=%03b data=%02h, expected 100 CC",
                         {out_valid, out_last, fifo_read}, out_data);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL stall_drain: %0d slices left, expected 0", sb_q.size());
        end
        checks++;
        if (pop_cnt - base_pop !== 2) begin
            errors++;
            $display("FAIL stall_pops: got %0d, expected 2", pop_cnt - base_pop);
        end
    endtask

    task automatic test_empty_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({fifo_read, out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL empty_idle: cycle %0d read/valid=%02b, expected 00",
                         i, {fifo_read, out_valid});
            end
        end
    endtask

    task automatic test_reset_mid_word();
        int base_x;
        int base_pop;
        bit hit;
        hit = 1'b0;
        @(posedge clk);
        #1;
        base_x = xfer_cnt;
        push_word(32'h1A2B3C4D);
        push_word(32'h55667788);
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            if (xfer_cnt - base_x >= 2) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midrst_reach: %0d slices moved, expected 2", xfer_cnt - base_x);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, fifo_read, out_last} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: valid/busy/read/last=%04b, expected 0000",
                     {out_valid, busy, fifo_read, out_last});
        end
        // The rest of the interrupted word is dropped.
        void'(sb_q.pop_front());
        void'(sb_q.pop_front());
        base_pop = pop_cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL midrst_drain: %0d slices left, expected 0", sb_q.size());
        end
        checks++;
        if (pop_cnt - base_pop !== 1) begin
            errors++;
            $display("FAIL midrst_pops: got %0d, expected 1", pop_cnt - base_pop);
        end
    endtask

    task automatic test_msb_first();
        logic [8:0] exp_q[$];
        logic [8:0] e;
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b0, 8'hBB});
        exp_q.push_back({1'b0, 8'hCC});
        exp_q.push_back({1'b1, 8'hDD});
        @(posedge clk);
        #1;
        m_data  = 32'hAABBCCDD;
        m_empty = 1'b0;
        @(negedge clk);
        checks++;
        if (m_read !== 1'b1) begin
            errors++;
            $display("FAIL msb_pop: fifo_read_o=%0b, expected 1", m_read);
        end
        @(posedge clk);
        #1 m_empty = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({m_valid, m_last, m_out} !== {1'b1, e}) begin
                errors++;
                $display("FAIL msb_slice: valid=%0b last=%0b data=%02h, expected 1 %0b %02h",
                         m_valid, m_last, m_out, e[8], e[7:0]);
            end
        end
        @(negedge clk);
        checks++;
        if ({m_valid, m_read} !== 2'b00) begin
            errors++;
            $display("FAIL msb_idle: valid/read=%02b, expected 00", {m_valid, m_read});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_empty_idle();
        test_reset_mid_word();
        test_msb_first();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_word_serializer.md
FIFO_WORD_SERIALIZER -- requirements
Module: fifo_word_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of the FIFO word consumed.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 8, width of each emitted slice.
REQ-003 The block SHALL have parameter LSB_FIRST, default 1; 1 emits the least-significant slice first, 0 the most-significant slice first.
REQ-004 The block SHALL use one clock, clk_i, with an asynchronous, active-high reset, rst_i.
REQ-005 The block SHALL have port clk_i, input, 1 bit, rising-edge clock.
REQ-006 The block SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port fifo_empty_i, input, 1 bit, empty flag of the upstream FWFT FIFO.
REQ-008 The block SHALL have port fifo_rd_data_i, input, DATA_WIDTH bits, head word of the FIFO, valid while fifo_empty_i=0.
REQ-009 The block SHALL have port fifo_read_o, output, 1 bit, pops the FIFO head on the rising edge.
REQ-010 The block SHALL have port out_data_o, output, OUT_WIDTH bits, current slice.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit, out_data_o holds a valid slice.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit, downstream accepts the slice.
REQ-013 The block SHALL have port out_last_o, output, 1 bit, current slice is the final slice of its word.
REQ-014 The block SHALL have port busy_o, output, 1 bit, a word is being serialized.

Function
REQ-015 RATIO = DATA_WIDTH/OUT_WIDTH; elaboration SHALL fail unless DATA_WIDTH is an exact multiple of OUT_WIDTH and RATIO >= 2.
REQ-016 The FSM SHALL have states IDLE and SHIFT; a slice counter of $clog2(RATIO) bits SHALL index the current slice.
REQ-017 IDLE with fifo_empty_i=0: fifo_read_o=1 combinationally; the word is captured into the holding register, counter=0, next state SHIFT (one-cycle latency from FIFO non-empty to first out_valid_o).
REQ-018 SHIFT: out_valid_o=1, busy_o=1; out_data_o = slice[counter] (slice 0 = bits OUT_WIDTH-1:0 when LSB_FIRST=1, top slice when LSB_FIRST=0).
REQ-019 Transfer occurs when out_valid_o=1 and out_ready_i=1; on a transfer with counter<RATIO-1, counter increments.
REQ-020 out_last_o SHALL be 1 exactly when in SHIFT and counter=RATIO-1.
REQ-021 Transfer of the last slice with fifo_empty_i=0: fifo_read_o=1 in that cycle, the next word is loaded, counter=0, state stays SHIFT (no bubble).
REQ-022 Transfer of the last slice with fifo_empty_i=1: next state IDLE, out_valid_o=0 next cycle.
REQ-023 While out_valid_o=1 and out_ready_i=0, out_data_o, out_last_o and counter SHALL hold and fifo_read_o SHALL be 0.
REQ-024 fifo_read_o SHALL never be 1 while fifo_empty_i=1, and SHALL pulse exactly once per word consumed.
REQ-025 Sustained throughput SHALL be one slice per cycle while the FIFO is non-empty and out_ready_i=1.

Reset
REQ-026 On rst_i=1, immediately and independent of clk_i: state IDLE, counter 0, holding register 0, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0, fifo_read_o=0.
REQ-027 Reset mid-word SHALL discard the remaining slices; after release, serialization restarts with slice 0 of the FIFO head word.

Structure
REQ-028 The state enum type and the RATIO/counter-width helper constants SHALL live in the shared package fifo_pkg.
REQ-029 The block SHALL be a single module with no sub-module; it connects directly to the FWFT sync FIFO read port.

Verification
REQ-030 FIFO holds 0xAABBCCDD, out_ready_i=1 -> slices 0xDD,0xCC,0xBB,0xAA on 4 consecutive cycles, out_last_o with 0xAA, one fifo_read_o pulse.
REQ-031 Words 0x03020100, 0x07060504, ready held 1 -> 0x00..0x07 on 8 consecutive cycles, second pop in the cycle 0x03 transfers.
REQ-032 out_ready_i=0 for 3 cycles while 0xCC presented -> 0xCC held stable, no pop, then 0xBB,0xAA follow.
REQ-033 fifo_empty_i=1 for 20 cycles -> fifo_read_o and out_valid_o stay 0.
REQ-034 rst_i raised after 2nd slice transfer -> out_valid_o=0 without clock edge; after release next head word starts at slice 0.
REQ-035 LSB_FIRST=0, word 0xAABBCCDD -> 0xAA,0xBB,0xCC,0xDD, out_last_o with 0xDD.
